// File: rtl/video_port_pkg.sv
// Shared definitions for the native video ports: port FSM states, default
// 1080p-style timing constants and a small counter window helper.
package video_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_RUN        = 2'd2,
    ST_FLUSH      = 2'd3
  } port_state_e;

  localparam int DEF_DSIZE    = 24;
  localparam int DEF_H_SYNC   = 44;
  localparam int DEF_H_BP     = 148;
  localparam int DEF_H_FP     = 88;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 36;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_SYNC_POL = 1;

  // True when cnt lies in [start, start+len); computed in 17 bits so the end cannot wrap.
  function automatic logic in_window(input logic [15:0] cnt,
                                     input logic [15:0] start,
                                     input logic [15:0] len);
    logic [16:0] stop;
    stop = {1'b0, start} + {1'b0, len};
    return ({1'b0, cnt} >= {1'b0, start}) && ({1'b0, cnt} < stop);
  endfunction

endpackage

// File: rtl/native_out_port_if.sv
// Stream input and video output bundle of the native output port.
interface native_out_port_if
  import video_port_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE
);
  logic             idata_vld;
  logic [DSIZE-1:0] idata;
  logic             falign;
  logic             lalign;
  logic             ealign;
  logic             idata_rdy;
  logic             vsync;
  logic             hsync;
  logic             de;
  logic [DSIZE-1:0] odata;
  logic             underflow;
  logic             resync;

  modport slave (
    input  idata_vld, idata, falign, lalign, ealign,
    output idata_rdy, vsync, hsync, de, odata, underflow, resync
  );

  modport master (
    output idata_vld, idata, falign, lalign, ealign,
    input  idata_rdy, vsync, hsync, de, odata, underflow, resync
  );
endinterface

// File: rtl/native_out_port_video_timing_gen.sv
// Horizontal/vertical counters and region decode for the native video ports.
// Active sizes are captured at frame start so mid-frame changes wait a frame.
module video_timing_gen
  import video_port_pkg::*;
#(
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int H_FP   = DEF_H_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter int V_FP   = DEF_V_FP
)(
  input  logic        clock,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] hactive,
  input  logic [15:0] vactive,
  output logic        frame_start,
  output logic        hsync_act,
  output logic        vsync_act,
  output logic        active,
  output logic        first_pix,
  output logic        last_line_pix,
  output logic        last_frame_pix
);

  localparam logic [15:0] H_ACT_START = 16'(H_SYNC + H_BP);
  localparam logic [15:0] V_ACT_START = 16'(V_SYNC + V_BP);
  localparam logic [15:0] H_SYNC_W    = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_W    = 16'(V_SYNC);
  localparam logic [15:0] H_FP_W      = 16'(H_FP);
  localparam logic [15:0] V_FP_W      = 16'(V_FP);

  logic [15:0] hcnt_r;
  logic [15:0] vcnt_r;
  logic [15:0] hact_r;
  logic [15:0] vact_r;
  logic [15:0] htotal_s;
  logic [15:0] vtotal_s;
  logic        h_act_s;
  logic        v_act_s;
  logic        last_col_s;
  logic        last_row_s;

  assign htotal_s    = H_ACT_START + hact_r + H_FP_W;
  assign vtotal_s    = V_ACT_START + vact_r + V_FP_W;
  assign frame_start = (hcnt_r == 16'd0) && (vcnt_r == 16'd0);

  // Capture active sizes only at frame start (continuously while idle).
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hact_r <= 16'd0;
      vact_r <= 16'd0;
    end else if (frame_start) begin
      hact_r <= hactive;
      vact_r <= vactive;
    end
  end

  // Pixel/line counters, forced to the frame origin whenever timing is stopped.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r <= 16'd0;
      vcnt_r <= 16'd0;
    end else if (!run) begin
      hcnt_r <= 16'd0;
      vcnt_r <= 16'd0;
    end else if (hcnt_r == htotal_s - 16'd1) begin
      hcnt_r <= 16'd0;
      if (vcnt_r == vtotal_s - 16'd1) begin
        vcnt_r <= 16'd0;
      end else begin
        vcnt_r <= vcnt_r + 16'd1;
      end
    end else begin
      hcnt_r <= hcnt_r + 16'd1;
    end
  end

  assign h_act_s        = in_window(hcnt_r, H_ACT_START, hact_r);
  assign v_act_s        = in_window(vcnt_r, V_ACT_START, vact_r);
  assign last_col_s     = (hcnt_r == H_ACT_START + hact_r - 16'd1);
  assign last_row_s     = (vcnt_r == V_ACT_START + vact_r - 16'd1);
  assign active         = h_act_s && v_act_s;
  assign hsync_act      = (hcnt_r < H_SYNC_W);
  assign vsync_act      = (vcnt_r < V_SYNC_W);
  assign first_pix      = active && (hcnt_r == H_ACT_START) && (vcnt_r == V_ACT_START);
  assign last_line_pix  = active && last_col_s;
  assign last_frame_pix = active && last_col_s && last_row_s;

endmodule

// File: rtl/native_out_port.sv
// Native video output port: turns an aligned pixel stream into sync/de/data
// timing, resynchronising on frame boundaries after underflow or misalignment.
module native_out_port
  import video_port_pkg::*;
#(
  parameter int DSIZE    = DEF_DSIZE,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_FP     = DEF_V_FP,
  parameter int SYNC_POL = DEF_SYNC_POL
)(
  input  logic               clock,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [15:0]        vactive,
  input  logic [15:0]        hactive,
  native_out_port_if.slave   port_if
);

  localparam logic SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  port_state_e      state_r;
  port_state_e      next_s;
  logic             run_s;
  logic             rdy_s;
  logic             accept_s;
  logic             align_err_s;
  logic             frame_start_s;
  logic             hsync_act_s;
  logic             vsync_act_s;
  logic             active_s;
  logic             first_pix_s;
  logic             last_line_s;
  logic             last_frame_s;
  logic             hsync_r;
  logic             vsync_r;
  logic             de_r;
  logic [DSIZE-1:0] odata_r;
  logic             underflow_r;
  logic             resync_r;

  video_timing_gen #(
    .H_SYNC (H_SYNC), .H_BP (H_BP), .H_FP (H_FP),
    .V_SYNC (V_SYNC), .V_BP (V_BP), .V_FP (V_FP)
  ) u_timing (
    .clock          (clock),
    .rst_n          (rst_n),
    .run            (run_s),
    .hactive        (hactive),
    .vactive        (vactive),
    .frame_start    (frame_start_s),
    .hsync_act      (hsync_act_s),
    .vsync_act      (vsync_act_s),
    .active         (active_s),
    .first_pix      (first_pix_s),
    .last_line_pix  (last_line_s),
    .last_frame_pix (last_frame_s)
  );

  // Counters start on the cycle after leaving IDLE and stop on the edge back into it.
  assign run_s       = (state_r != ST_IDLE) && (next_s != ST_IDLE);
  assign accept_s    = port_if.idata_vld && rdy_s;
  assign align_err_s = (port_if.falign != first_pix_s) ||
                       (port_if.lalign != last_line_s) ||
                       (port_if.ealign != last_frame_s);

  // Ready decode: a frame-head beat is held back for the next frame start; never looks at idata_vld.
  always_comb begin
    rdy_s = 1'b0;
    case (state_r)
      ST_RUN:                  rdy_s = active_s;
      ST_WAIT_FRAME, ST_FLUSH: rdy_s = !active_s && !port_if.falign;
      default:                 rdy_s = 1'b0;
    endcase
  end

  // Next-state decode; enable and resync only take effect at frame start.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) next_s = ST_WAIT_FRAME;
        else        next_s = ST_IDLE;
      end
      ST_WAIT_FRAME, ST_FLUSH: begin
        if (frame_start_s && !enable)                                     next_s = ST_IDLE;
        else if (frame_start_s && port_if.idata_vld && port_if.falign)    next_s = ST_RUN;
        else                                                              next_s = state_r;
      end
      ST_RUN: begin
        if (frame_start_s && !enable)      next_s = ST_IDLE;
        else if (accept_s && align_err_s)  next_s = ST_FLUSH;
        else                               next_s = ST_RUN;
      end
      default: next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_s;
  end

  // Video outputs and error pulses, one clock behind the counter state.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hsync_r     <= ~SYNC_ON;
      vsync_r     <= ~SYNC_ON;
      de_r        <= 1'b0;
      odata_r     <= {DSIZE{1'b0}};
      underflow_r <= 1'b0;
      resync_r    <= 1'b0;
    end else begin
      hsync_r     <= (run_s && hsync_act_s) ? SYNC_ON : ~SYNC_ON;
      vsync_r     <= (run_s && vsync_act_s) ? SYNC_ON : ~SYNC_ON;
      de_r        <= run_s && active_s;
      odata_r     <= ((state_r == ST_RUN) && accept_s) ? port_if.idata : {DSIZE{1'b0}};
      underflow_r <= (state_r == ST_RUN) && active_s && !port_if.idata_vld;
      resync_r    <= (state_r == ST_RUN) && accept_s && align_err_s;
    end
  end

  assign port_if.idata_rdy = rdy_s;
  assign port_if.hsync     = hsync_r;
  assign port_if.vsync     = vsync_r;
  assign port_if.de        = de_r;
  assign port_if.odata     = odata_r;
  assign port_if.underflow = underflow_r;
  assign port_if.resync    = resync_r;

endmodule

// File: doc/native_out_port.md
NATIVE_OUT_PORT -- requirements
Module: native_out_port

Interface
REQ-001 SHALL have parameter DSIZE, default 24, pixel data width.
REQ-002 SHALL have parameters H_SYNC/H_BP/H_FP, defaults 44/148/88, horizontal sync, back-porch and front-porch widths in clocks.
REQ-003 SHALL have parameters V_SYNC/V_BP/V_FP, defaults 5/36/4, vertical sync, back-porch and front-porch heights in lines.
REQ-004 SHALL have parameter SYNC_POL, default 1, active level of vsync/hsync.
REQ-005 clock  input  1  single clock for all logic.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 enable  input  1  start/keep timing generation; sampled at frame start only.
REQ-008 vactive, hactive  input  16 each  active lines and pixels per line; sampled at frame start; both must be >=1.
REQ-009 idata_vld, idata[DSIZE], falign, lalign, ealign  input  stream beat with first-of-frame, last-of-line and last-of-frame flags.
REQ-010 idata_rdy  output  1  beat accepted when idata_vld && idata_rdy.
REQ-011 vsync, hsync, de  output  1 each  video timing.
REQ-012 odata  output  DSIZE  pixel data, zero outside de.
REQ-013 underflow, resync  output  1 each  single-cycle error pulses.

Function
REQ-014 Line timing SHALL be hsync(H_SYNC), back porch(H_BP), active(hactive), front porch(H_FP); htotal = sum, hcnt 16-bit, wraps at htotal-1.
REQ-015 Frame timing SHALL be vsync(V_SYNC), V_BP, vactive, V_FP lines; vcnt increments at hcnt wrap and wraps at vtotal-1.
REQ-016 vsync SHALL change only at hcnt==0; de SHALL be high exactly when both counters are in their active regions.
REQ-017 All timing and data outputs SHALL be registered, one clock after counter state; idata_rdy SHALL be combinational from counter state and FSM state only (never from idata_vld).
REQ-018 FSM states: IDLE, WAIT_FRAME, RUN, FLUSH.
REQ-019 IDLE: counters held at 0, outputs inactive; at enable=1 go WAIT_FRAME and start counting.
REQ-020 WAIT_FRAME/FLUSH: idata_rdy=1 outside active region for beats without falign (discarded); a beat with falign SHALL be held (rdy=0); de timing runs with odata=0.
REQ-021 At frame start (hcnt==0, vcnt==0): if head beat valid with falign, go RUN; else remain; if enable=0, go IDLE.
REQ-022 RUN: idata_rdy=1 during active pixels; accepted beat drives odata next cycle.
REQ-023 RUN, active pixel with idata_vld=0: counters SHALL advance, odata=0, underflow pulse; subsequent beats continue in order.
REQ-024 RUN, alignment checks on accepted beats: falign iff first active pixel of frame; lalign iff last active pixel of line; ealign iff last active pixel of frame.
REQ-025 Any check failure SHALL pulse resync and enter FLUSH; pixel still output as received.
REQ-026 enable deasserted in RUN SHALL take effect at the next frame start (go IDLE); a frame in progress completes.
REQ-027 hactive/vactive changes mid-frame SHALL be ignored until next frame start.

Reset
REQ-028 rst_n=0 SHALL asynchronously force FSM=IDLE, counters=0, vsync=hsync=!SYNC_POL, de=0, odata=0, idata_rdy=0, underflow=0, resync=0.
REQ-029 Reset mid-frame SHALL abort without draining; after release, behaviour is identical to power-up.

Structure
REQ-030 FSM state enum and default timing constants SHALL live in shared package video_port_pkg, shared with the input port.
REQ-031 Counters and region decode SHALL be sub-module video_timing_gen; native_out_port holds FSM, handshake and checks.

Verification (hactive=4, vactive=2, H_SYNC=1,H_BP=1,H_FP=2, V_SYNC=1,V_BP=1,V_FP=1: htotal=8, vtotal=5)
REQ-032 Reset then enable=1, stream 8 beats with correct flags always valid -> de high 4 clocks per line on lines 2-3, odata equals beats in order, no error pulses, 40-clock frame period.
REQ-033 idata_vld low for the 3rd pixel of the frame -> underflow one pulse, odata=0 that pixel, 3rd beat appears at pixel 4.
REQ-034 lalign missing on pixel 4 of line 2 -> resync pulse, FLUSH; next frame with falign beat present -> RUN, clean output.
REQ-035 Stream starts with 3 beats without falign then falign frame -> 3 beats discarded, first displayed pixel is the falign beat at first active pixel of the next frame start.
REQ-036 enable dropped at mid-frame -> frame completes, then outputs idle, idata_rdy=0.
REQ-037 rst_n asserted mid-active-line -> all outputs reach reset values same cycle, no clock edge required.
